// File: rtl/vec_reg_copy_ctrl.sv
// Copies a run of consecutive vector registers through a single-port register file:
// read, capture, write for each register, in ascending order, with addresses wrapping.
module vec_reg_copy_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_src,
  input  logic [ADDR_WIDTH-1:0] req_dst,
  input  logic [3:0]            req_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_en,
  output logic                  rf_rw,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;

  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rf_en_q, rf_en_d;
  logic                  rf_rw_q, rf_rw_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          src_d   = req_src;
          dst_d   = req_dst;
          cnt_d   = req_cnt;
          idx_d   = 4'd0;
          state_d = (req_cnt == 4'd0) ? DONE : RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        buf_d   = rf_rdata;
        state_d = WR;
      end
      WR: begin
        idx_d   = idx_q + 4'd1;
        state_d = (({1'b0, idx_q} + 5'd1) < {1'b0, cnt_q}) ? RD : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and then registered, so they are
    // glitch-free flops with no combinational path from req_* to the regfile port.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d == RD) || (state_d == CAP) || (state_d == WR);
    done_d      = (state_d == DONE);
    rf_en_d     = (state_d == RD) || (state_d == WR);
    rf_rw_d     = (state_d == WR);
    if (state_d == RD) begin
      rf_addr_d = src_d + ADDR_WIDTH'(idx_d);
    end else if (state_d == WR) begin
      rf_addr_d = dst_d + ADDR_WIDTH'(idx_d);
    end else begin
      rf_addr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      // NOTE: the capture buffer is a plain register, not a memory array, so clearing
      // it on reset costs nothing and keeps rf_wdata at zero out of reset.
      buf_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rf_en_q     <= 1'b0;
      rf_rw_q     <= 1'b0;
      rf_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rf_en_q     <= rf_en_d;
      rf_rw_q     <= rf_rw_d;
      rf_addr_q   <= rf_addr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rf_en     = rf_en_q;
  assign rf_rw     = rf_rw_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = buf_q;

endmodule

// File: tb/tb_vec_reg_copy_ctrl.sv
// Bench for vec_reg_copy_ctrl: a behavioural regfile, a table of directed copies,
// random copies against an array model, and reset/ignore corner sequences.
module tb_vec_reg_copy_ctrl;

  localparam int DW = 128;
  localparam int AW = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_src = '0;
  logic [AW-1:0] req_dst = '0;
  logic [3:0]    req_cnt = '0;
  logic          busy;
  logic          done;
  logic          rf_en;
  logic          rf_rw;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;

  logic [DW-1:0] mem     [NREG];
  logic [DW-1:0] ref_mem [NREG];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int total = 0;
  int bad = 0;

  vec_reg_copy_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_cnt   (req_cnt),
    .busy      (busy),
    .done      (done),
    .rf_en     (rf_en),
    .rf_rw     (rf_rw),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  always #5 clk = ~clk;

  // Single-port regfile: access sampled at the edge, read data valid the next cycle.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (rf_en && rf_rw) mem[rf_addr] <= rf_wdata;
    if (rf_en && !rf_rw) rf_rdata <= mem[rf_addr];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[addr] = data;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference semantics: sequential element-by-element copy, modulo-32 addresses.
  task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int cnt);
    logic [AW-1:0] s, d;
    for (int i = 0; i < cnt; i++) begin
      s = AW'(int'(src) + i);
      d = AW'(int'(dst) + i);
      ref_mem[d] = ref_mem[s];
    end
  endtask

  task automatic check_mem(input string name);
    int err = 0;
    for (int r = 0; r < NREG; r++) if (mem[r] !== ref_mem[r]) err++;
    check(name, err, 0);
  endtask

  // Issues one request and observes every cycle until done (bounded). With noise set,
  // req_valid stays high and the request fields change while the copy runs.
  task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int cnt,
                          input bit noise, input string name, output int done_cyc);
    int trace_err = 0;
    int n_acc = 0;
    int i_reg, ph;
    bit exp_busy, exp_en, exp_rw;
    logic [AW-1:0] ea;
    @(negedge clk);
    req_valid = 1'b1;
    req_src = src;
    req_dst = dst;
    req_cnt = 4'(cnt);
    @(posedge clk);
    #1;
    if (noise) begin
      req_src = ~src;
      req_dst = ~dst;
      req_cnt = ~4'(cnt);
    end else begin
      req_valid = 1'b0;
    end
    done_cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      i_reg = (k - 1) / 3;
      ph = (k - 1) % 3;
      exp_busy = (k <= 3 * cnt);
      exp_en = exp_busy && (ph != 1);
      exp_rw = (ph == 2);
      ea = (ph == 0) ? AW'(int'(src) + i_reg) : AW'(int'(dst) + i_reg);
      if (rf_en) n_acc++;
      if (rf_en !== exp_en || busy !== exp_busy || req_ready !== 1'b0 ||
          (exp_en && (rf_rw !== exp_rw || rf_addr !== ea)))
        trace_err++;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    req_valid = 1'b0;
    check({name, " trace"}, trace_err, 0);
    check({name, " accesses"}, n_acc, 2 * cnt);
    @(negedge clk);
    check({name, " ready_after_done"}, req_ready, 1'b1);
    model_copy(src, dst, cnt);
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int            cnt;
    bit            noise;
    int            exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] va, vb, old_src;
    int dc;
    logic [AW-1:0] rs, rd;
    int rc;
    bit seen_done;

    vecs[0] = '{src: 5'd0,  dst: 5'd5,  cnt: 1, noise: 1'b0, exp_done: 4};
    vecs[1] = '{src: 5'd8,  dst: 5'd16, cnt: 4, noise: 1'b0, exp_done: 13};
    vecs[2] = '{src: 5'd30, dst: 5'd2,  cnt: 3, noise: 1'b0, exp_done: 10};
    vecs[3] = '{src: 5'd4,  dst: 5'd5,  cnt: 2, noise: 1'b1, exp_done: 7};
    vecs[4] = '{src: 5'd9,  dst: 5'd9,  cnt: 0, noise: 1'b0, exp_done: 1};
    vecs[5] = '{src: 5'd12, dst: 5'd12, cnt: 2, noise: 1'b0, exp_done: 7};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst req_ready", req_ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst rf_en", rf_en, 1'b0);
    check("rst rf_rw", rf_rw, 1'b0);
    check("rst rf_addr", rf_addr, '0);
    check("rst rf_wdata", rf_wdata, '0);
    rst_n = 1'b1;

    for (int r = 0; r < NREG; r++) preload(AW'(r), rand_word());
    preload(5'd0, 128'hABCDEF0123456789);
    for (int r = 8; r < 12; r++) preload(AW'(r), {96'h0, 32'h1111_0000 + 32'(r)});

    // Directed table
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        va = rand_word();
        vb = ~va;
        preload(5'd4, va);
        preload(5'd5, vb);
      end
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].cnt, vecs[i].noise, $sformatf("vec%0d", i), dc);
      check($sformatf("vec%0d done_cycle", i), dc, vecs[i].exp_done);
      check_mem($sformatf("vec%0d mem", i));
      if (i == 0) check("single v5 data", mem[5], 128'hABCDEF0123456789);
      if (i == 3) begin
        check("overlap v5", mem[5], va);
        check("overlap v6", mem[6], va);
      end
    end

    // Random copies against the array model
    for (int t = 0; t < 20; t++) begin
      rs = AW'($urandom_range(0, NREG - 1));
      rd = AW'($urandom_range(0, NREG - 1));
      rc = $urandom_range(0, 15);
      run_copy(rs, rd, rc, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t), dc);
      check($sformatf("rnd%0d done_cycle", t), dc, 3 * rc + 1);
      check_mem($sformatf("rnd%0d mem", t));
    end

    // Reset mid-copy: first write lands (edge 3), reset during the second capture
    old_src = ref_mem[20];
    @(negedge clk);
    req_valid = 1'b1;
    req_src = 5'd20;
    req_dst = 5'd24;
    req_cnt = 4'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst req_ready", req_ready, 1'b1);
    check("midrst busy", busy, 1'b0);
    check("midrst rf_en", rf_en, 1'b0);
    check("midrst rf_addr", rf_addr, '0);
    check("midrst rf_wdata", rf_wdata, '0);
    seen_done = done;
    repeat (3) begin
      @(negedge clk);
      if (done || rf_en) seen_done = 1'b1;
    end
    check("midrst no done/access", seen_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ref_mem[24] = old_src;
    check("midrst v24 written", mem[24], old_src);
    check_mem("midrst mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
